obi_axi_lite_master: RTL
========================

OBI_AXI_LITE_MASTER -- requirements
Module: obi_axi_lite_master

Interface
REQ-001 Parameter AXI_AW, default 16, address width of the core and AXI sides.
REQ-002 Parameter AXI_DW, default 32, data width, a multiple of 8; strobe width is AXI_DW/8.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Ports, clock and reset first:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- req_i  in  1  core request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AXI_AW  byte address
- wdata_i  in  AXI_DW  write data
- be_i  in  AXI_DW/8  byte enables
- gnt_o  out  1  request accepted
- rvalid_o  out  1  response pulse
- rdata_o  out  AXI_DW  read data
- err_o  out  1  response error
- aw_addr_o  out  AXI_AW; aw_valid_o  out  1; aw_ready_i  in  1
- w_data_o  out  AXI_DW; w_strb_o  out  AXI_DW/8; w_valid_o  out  1; w_ready_i  in  1
- b_resp_i  in  2; b_valid_i  in  1; b_ready_o  out  1
- ar_addr_o  out  AXI_AW; ar_valid_o  out  1; ar_ready_i  in  1
- r_data_i  in  AXI_DW; r_resp_i  in  2; r_valid_i  in  1; r_ready_o  out  1

Function
REQ-005 The FSM SHALL have the states IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R and RESP, with at most one transaction outstanding.
REQ-006 In IDLE, gnt_o SHALL equal req_i combinationally; in every other state gnt_o SHALL be 0.
REQ-007 On req_i and gnt_o, the block SHALL register addr_i, wdata_i, be_i and we_i, then go to WR_ADDR_DATA if we_i = 1, else to RD_ADDR.
REQ-008 In WR_ADDR_DATA, aw_valid_o and w_valid_o SHALL assert in the first cycle.
- Each valid SHALL drop in the cycle after its own handshake (valid and ready).
- The block SHALL keep a separate aw_done and w_done flag for each channel.
- When both handshakes are complete, whether in the same cycle or in different cycles, the FSM SHALL go to WAIT_B.
REQ-009 A valid, once asserted, SHALL NOT drop and its payload SHALL NOT change before its handshake.
REQ-010 aw_addr_o and ar_addr_o SHALL carry the registered address.
REQ-011 w_data_o and w_strb_o SHALL carry the registered data and byte enables.
REQ-012 In WAIT_B, b_ready_o SHALL be 1; on b_valid_i, the block SHALL capture err = b_resp_i[1] and go to RESP.
REQ-013 In RD_ADDR, ar_valid_o SHALL be 1; on ar_ready_i, the FSM SHALL go to WAIT_R.
REQ-014 In WAIT_R, r_ready_o SHALL be 1; on r_valid_i, the block SHALL capture r_data_i into rdata_o, capture err = r_resp_i[1] and go to RESP.
REQ-015 In RESP, rvalid_o SHALL be 1 for exactly one cycle and err_o SHALL show the captured error; the FSM SHALL then go to IDLE.
REQ-016 rdata_o SHALL hold its last read value until the next R capture; writes SHALL NOT alter rdata_o.
REQ-017 When rvalid_o = 0, err_o SHALL be 0.
REQ-018 Latency with all slave readies and valids already high SHALL be:
- write: grant in cycle 0, AW and W handshake in cycle 1, B in cycle 2, rvalid_o in cycle 3.
- read: grant in cycle 0, AR in cycle 1, R in cycle 2, rvalid_o in cycle 3.
REQ-019 A req_i held high during RESP SHALL be granted in the following IDLE cycle; back-to-back throughput SHALL be one transaction per 4 cycles best case.
REQ-020 b_valid_i or r_valid_i arriving outside WAIT_B or WAIT_R SHALL be ignored, with b_ready_o and r_ready_o held at 0.
REQ-021 Any response code with bit 1 set (SLVERR 2'b10, DECERR 2'b11) SHALL set err_o.
REQ-022 OKAY (2'b00) and EXOKAY (2'b01) SHALL NOT set err_o.

Reset
REQ-023 While rst_i = 1, the FSM SHALL be in IDLE and the following SHALL all be 0:
- every valid and ready output, rvalid_o and err_o;
- rdata_o, the registered command and both done flags.
REQ-024 Reset asserted mid-transaction SHALL abort it immediately, with all AXI valids 0 in the next cycle; no rvalid_o SHALL be produced for the aborted transaction.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Write 0x0040, wdata 0xDEADBEEF, be 4'hF, slave always ready -> aw_valid_o and w_valid_o in cycle 1, b_ready_o in cycle 2, rvalid_o=1 and err_o=0 in cycle 3.
- Read 0x0040 against a slave that returns 0xDEADBEEF with r_resp 2'b00 -> rdata_o=0xDEADBEEF, rvalid_o for one cycle, err_o=0.
- aw_ready_i high at cycle 1 and w_ready_i delayed to cycle 4 -> aw_valid_o low from cycle 2, w_data_o stable until cycle 4, single B accepted, exactly one rvalid_o.
- Read with r_resp_i=2'b10 after 3 wait cycles -> r_ready_o high throughout WAIT_R, rvalid_o=1 with err_o=1, rdata_o updated.
- req_i held high across two writes -> gnt_o pulses in cycles 0 and 4, two rvalid_o pulses in cycles 3 and 7.
- rst_i pulsed during WAIT_R -> r_ready_o=0 next cycle, no rvalid_o, next read completes normally.
- Back-to-back against the AXI-lite slave bridge (AW then W sequencing, one-cycle-late r_valid) -> write 0x12345678 to 0x0010 then read 0x0010 returns 0x12345678.

Source files
------------

// File: rtl/obi_axi_lite_master.sv
// OBI-style core port to AXI4-Lite master bridge with a single outstanding transaction.
// The core gets one rvalid_o pulse per accepted request; err_o reflects BRESP/RRESP bit 1.
module obi_axi_lite_master #(
    parameter int unsigned AXI_AW = 16,
    parameter int unsigned AXI_DW = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [AXI_AW-1:0]     addr_i,
    input  logic [AXI_DW-1:0]     wdata_i,
    input  logic [AXI_DW/8-1:0]   be_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [AXI_DW-1:0]     rdata_o,
    output logic                  err_o,
    output logic [AXI_AW-1:0]     aw_addr_o,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [AXI_DW-1:0]     w_data_o,
    output logic [AXI_DW/8-1:0]   w_strb_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    input  logic [1:0]            b_resp_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [AXI_AW-1:0]     ar_addr_o,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    input  logic [AXI_DW-1:0]     r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WAIT_B,
        RD_ADDR,
        WAIT_R,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic [AXI_AW-1:0]     addr_q;
    logic [AXI_DW-1:0]     wdata_q;
    logic [AXI_DW/8-1:0]   be_q;
    logic                  we_q;
    logic                  aw_done_q, w_done_q;
    logic                  err_q;
    logic [AXI_DW-1:0]     rdata_q;
    logic                  aw_hs, w_hs;

    // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp inside {2'b10, 2'b11};
    endfunction

    always_comb begin
        state_d    = state_q;
        gnt_o      = 1'b0;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;
        rvalid_o   = 1'b0;
        err_o      = 1'b0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) state_d = we_i ? WR_ADDR_DATA : RD_ADDR;
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; leave once both have handshaken.
                aw_valid_o = !aw_done_q;
                w_valid_o  = !w_done_q;
                aw_hs      = !aw_done_q && aw_ready_i;
                w_hs       = !w_done_q && w_ready_i;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WAIT_B;
            end
            WAIT_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) state_d = RESP;
            end
            RD_ADDR: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) state_d = WAIT_R;
            end
            WAIT_R: begin
                r_ready_o = 1'b1;
                if (r_valid_i) state_d = RESP;
            end
            RESP: begin
                rvalid_o = 1'b1;
                err_o    = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_i) begin
                addr_q    <= addr_i;
                wdata_q   <= wdata_i;
                be_q      <= be_i;
                we_q      <= we_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (state_q == WAIT_B && b_valid_i) err_q <= resp_is_err(b_resp_i);
            if (state_q == WAIT_R && r_valid_i) begin
                err_q   <= resp_is_err(r_resp_i);
                rdata_q <= r_data_i;
            end
        end
    end

    assign aw_addr_o = addr_q;
    assign ar_addr_o = addr_q;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = be_q;
    assign rdata_o   = rdata_q;

endmodule
